// File: rtl/wb_pkg.sv
// Shared types for the Wishbone round-robin arbiter.
// Build option: define WB_ARB_TIMEOUT_EN to add the slave watchdog and the ABORT state.
package wb_pkg;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ABORT
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;
`endif

    // Termination kind of a slave transfer.
    typedef enum logic {
        RET_ACK,
        RET_ERR
    } ret_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_i,
// wrapping from NUM_MASTERS-1 back to 0.
module wb_rr_pick #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]       last_i,
    output logic                   valid_o,
    output logic [IDX_W-1:0]       idx_o
);

    // Scan masters in rotated priority order, keep the first hit.
    always_comb begin
        logic [IDX_W-1:0] cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((32'(last_i) + k) % NUM_MASTERS);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave.
// Build option: define WB_ARB_TIMEOUT_EN to enable the stalled-strobe watchdog
// (TIMEOUT_CYCLES), which errors the master and parks in ABORT until it drops cyc.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned GRANULE        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned SEL_WIDTH     = DATA_WIDTH / GRANULE,
    localparam int unsigned IDX_W         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    output logic [NUM_MASTERS-1:0]            gnt_o
);

    if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wb_rr_arbiter: NUM_MASTERS must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NUM_MASTERS-1:0] gnt_d;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;

    logic                   g_cyc, g_stb, g_we;
    logic [ADDR_WIDTH-1:0]  g_adr;
    logic [DATA_WIDTH-1:0]  g_dat;
    logic [SEL_WIDTH-1:0]   g_sel;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // Select the currently granted master's bus signals.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (gidx_q == IDX_W'(i)) begin
                g_cyc = m_cyc_i[i];
                g_stb = m_stb_i[i];
                g_we  = m_we_i[i];
                g_adr = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                g_sel = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    // Next-state, grant and slave/master routing.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        gnt_d   = gnt_o;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gidx_d           = pick_idx;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    state_d          = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (g_cyc) begin
                    s_cyc_o = 1'b1;
                    s_stb_o = g_stb;
                    s_we_o  = g_we;
                    s_adr_o = g_adr;
                    s_dat_o = g_dat;
                    s_sel_o = g_sel;
                    m_dat_o = s_dat_i;
                    m_ack_o = gnt_o & {NUM_MASTERS{s_ack_i}};
                    m_err_o = gnt_o & {NUM_MASTERS{s_err_i}};
`ifdef WB_ARB_TIMEOUT_EN
                    if (g_stb && !s_ack_i && !s_err_i) begin
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            m_err_o = gnt_o;
                            state_d = ST_ABORT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
`endif
                end else begin
                    last_d  = gidx_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_ABORT: begin
                if (!g_cyc) begin
                    last_d  = gidx_q;
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            gnt_o   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            gnt_o   <= gnt_d;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (default parameters: 4 masters, 16-bit
// address, 32-bit data). Honours WB_ARB_TIMEOUT_EN when defined.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [N*AW-1:0] m_adr_i = '0;
    logic [N*DW-1:0] m_dat_i = '0;
    logic [N*SW-1:0] m_sel_i = '0;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: current owner (-1 = none), last owner, abort flag, stall count.
    int owner   = -1;
    int last_m  = N - 1;
    bit abort_m = 1'b0;
    int cnt_m   = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .GRANULE        (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_sel_i (m_sel_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .gnt_o   (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0] cyc;
        logic         ack;
        logic [N-1:0] exp_gnt;
        logic         exp_scyc;
        logic [N-1:0] exp_ack;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_master(input int i, input logic cyc, input logic stb, input logic we,
                              input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m_cyc_i[i] = cyc;
        m_stb_i[i] = stb;
        m_we_i[i]  = we;
        m_adr_i[i*AW +: AW] = adr;
        m_dat_i[i*DW +: DW] = dat;
        m_sel_i[i*SW +: SW] = 4'hF;
    endtask

    task automatic do_reset();
        rst_i   = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i   = 1'b1;
        owner   = -1;
        last_m  = N - 1;
        abort_m = 1'b0;
        cnt_m   = 0;
    endtask

    // Advance the reference model over one rising edge using the inputs seen there.
    task automatic model_step();
        bit found;
        if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (last_m + k) % N;
                if (!found && m_cyc_i[p]) begin
                    owner = p;
                    found = 1'b1;
                end
            end
            abort_m = 1'b0;
            cnt_m   = 0;
        end else if (!m_cyc_i[owner]) begin
            last_m  = owner;
            owner   = -1;
            abort_m = 1'b0;
            cnt_m   = 0;
        end else if (!abort_m) begin
`ifdef WB_ARB_TIMEOUT_EN
            if (m_stb_i[owner] && !s_ack_i && !s_err_i) begin
                cnt_m++;
                if (cnt_m == TO) begin
                    abort_m = 1'b1;
                    cnt_m   = 0;
                end
            end else begin
                cnt_m = 0;
            end
`endif
        end
    endtask

    task automatic check_all();
        bit           live;
        bit           tmo;
        logic [N-1:0] e_gnt, e_ack, e_err;
        live  = (owner >= 0) && !abort_m && m_cyc_i[owner];
        tmo   = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        tmo   = live && m_stb_i[owner] && !s_ack_i && !s_err_i && (cnt_m + 1 == TO);
`endif
        e_gnt = (owner >= 0) ? N'(1 << owner) : '0;
        e_ack = live ? N'(int'(s_ack_i) << owner) : '0;
        e_err = live ? N'(int'(s_err_i | tmo) << owner) : '0;
        check("rnd_gnt",   gnt_o,   e_gnt);
        check("rnd_s_cyc", s_cyc_o, live);
        check("rnd_s_stb", s_stb_o, live ? m_stb_i[owner] : 1'b0);
        check("rnd_s_we",  s_we_o,  live ? m_we_i[owner]  : 1'b0);
        check("rnd_s_adr", s_adr_o, live ? m_adr_i[owner*AW +: AW] : '0);
        check("rnd_s_dat", s_dat_o, live ? m_dat_i[owner*DW +: DW] : '0);
        check("rnd_s_sel", s_sel_o, live ? m_sel_i[owner*SW +: SW] : '0);
        check("rnd_m_dat", m_dat_o, live ? s_dat_i : '0);
        check("rnd_m_ack", m_ack_o, e_ack);
        check("rnd_m_err", m_err_o, e_err);
    endtask

    initial begin
        // Three simultaneous requesters out of reset: 0, 1, 2 with one dead cycle between.
        vecs[0] = '{4'b0111, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[1] = '{4'b0111, 1'b1, 4'b0001, 1'b1, 4'b0001};
        vecs[2] = '{4'b0110, 1'b0, 4'b0001, 1'b0, 4'b0000};
        vecs[3] = '{4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[4] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 4'b0010};
        vecs[5] = '{4'b0100, 1'b0, 4'b0010, 1'b0, 4'b0000};
        vecs[6] = '{4'b0100, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vecs[7] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
        vecs[8] = '{4'b0000, 1'b0, 4'b0100, 1'b0, 4'b0000};
        vecs[9] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};

        do_reset();
        check("reset_gnt",   gnt_o,   4'b0000);
        check("reset_s_cyc", s_cyc_o, 1'b0);
        check("reset_ack",   m_ack_o, 4'b0000);
        for (int r = 0; r < 10; r++) begin
            @(posedge clk_i);
            #1;
            m_cyc_i = vecs[r].cyc;
            m_stb_i = vecs[r].cyc;
            s_ack_i = vecs[r].ack;
            @(negedge clk_i);
            check($sformatf("tbl%0d_gnt", r),   gnt_o,   vecs[r].exp_gnt);
            check($sformatf("tbl%0d_s_cyc", r), s_cyc_o, vecs[r].exp_scyc);
            check($sformatf("tbl%0d_ack", r),   m_ack_o, vecs[r].exp_ack);
        end

        // Master 1 single read, slave acks two cycles after grant.
        do_reset();
        @(posedge clk_i); #1;
        set_master(1, 1'b1, 1'b1, 1'b0, 16'h0004, '0);
        @(negedge clk_i);
        check("rd_gnt0", gnt_o, 4'b0000);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rd_gnt1", gnt_o,   4'b0010);
        check("rd_adr",  s_adr_o, 16'h0004);
        check("rd_scyc", s_cyc_o, 1'b1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEADBEEF;
        @(negedge clk_i);
        check("rd_ack", m_ack_o, 4'b0010);
        check("rd_dat", m_dat_o, 32'hDEADBEEF);
        @(posedge clk_i); #1;
        s_ack_i = 1'b0;
        set_master(1, 1'b0, 1'b0, 1'b0, '0, '0);

        // Master 0 read-modify-write keeps the bus while master 3 waits.
        do_reset();
        @(posedge clk_i); #1;
        set_master(0, 1'b1, 1'b1, 1'b0, 16'h0008, 32'h1111_2222);
        set_master(3, 1'b1, 1'b1, 1'b0, 16'h0030, 32'h3333_4444);
        @(negedge clk_i);
        check("rmw_gnt0", gnt_o, 4'b0000);
        @(posedge clk_i); #1;
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("rmw_gnt_rd", gnt_o,   4'b0001);
        check("rmw_adr",    s_adr_o, 16'h0008);
        check("rmw_ack_rd", m_ack_o, 4'b0001);
        @(posedge clk_i); #1;
        s_ack_i = 1'b0;
        m_stb_i[0] = 1'b0;
        @(negedge clk_i);
        check("rmw_gnt_gap", gnt_o,   4'b0001);
        check("rmw_stb_gap", s_stb_o, 1'b0);
        check("rmw_cyc_gap", s_cyc_o, 1'b1);
        @(posedge clk_i); #1;
        m_stb_i[0] = 1'b1;
        m_we_i[0]  = 1'b1;
        s_ack_i    = 1'b1;
        @(negedge clk_i);
        check("rmw_gnt_wr", gnt_o,   4'b0001);
        check("rmw_we",     s_we_o,  1'b1);
        check("rmw_ack_wr", m_ack_o, 4'b0001);
        @(posedge clk_i); #1;
        s_ack_i = 1'b0;
        set_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk_i);
        check("rmw_drop_gnt", gnt_o,   4'b0001);
        check("rmw_drop_cyc", s_cyc_o, 1'b0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rmw_dead_gnt", gnt_o, 4'b0000);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rmw_m3_gnt", gnt_o,   4'b1000);
        check("rmw_m3_adr", s_adr_o, 16'h0030);

        // Asynchronous reset in the middle of a master 2 write.
        do_reset();
        @(posedge clk_i); #1;
        set_master(2, 1'b1, 1'b1, 1'b1, 16'h0100, 32'hCAFE_F00D);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rstw_gnt", gnt_o,   4'b0100);
        check("rstw_we",  s_we_o,  1'b1);
        #2;
        s_ack_i = 1'b1;
        rst_i   = 1'b0;
        #1;
        check("rstw_gnt_async", gnt_o,   4'b0000);
        check("rstw_cyc_async", s_cyc_o, 1'b0);
        check("rstw_no_ack",    m_ack_o, 4'b0000);
        @(negedge clk_i);
        s_ack_i = 1'b0;
        rst_i   = 1'b1;
        set_master(0, 1'b1, 1'b1, 1'b0, 16'h0200, '0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("rstw_m0_first", gnt_o, 4'b0001);

`ifdef WB_ARB_TIMEOUT_EN
        // Slave never acks: error after exactly TO strobe cycles, then ABORT.
        do_reset();
        @(posedge clk_i); #1;
        set_master(0, 1'b1, 1'b1, 1'b0, 16'h0040, '0);
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            if (k == TO - 1) check("to_err_early", m_err_o, 4'b0000);
            if (k == TO)     check("to_err_pulse", m_err_o, 4'b0001);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("to_abort_cyc", s_cyc_o, 1'b0);
        check("to_abort_gnt", gnt_o,   4'b0001);
        check("to_abort_err", m_err_o, 4'b0000);
        @(posedge clk_i); #1;
        set_master(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("to_release_gnt", gnt_o, 4'b0000);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i);
            model_step();
            #1;
            for (int i = 0; i < N; i++) begin
                if (m_cyc_i[i]) begin
                    if ($urandom_range(7) == 0) m_cyc_i[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    m_cyc_i[i] = 1'b1;
                end
                m_stb_i[i] = m_cyc_i[i] & ($urandom_range(3) != 0);
                m_we_i[i]  = 1'($urandom);
                m_adr_i[i*AW +: AW] = 16'($urandom);
                m_dat_i[i*DW +: DW] = $urandom;
                m_sel_i[i*SW +: SW] = 4'($urandom);
            end
            s_ack_i = 1'($urandom_range(1));
            s_err_i = ($urandom_range(15) == 0);
            s_dat_i = $urandom;
            @(negedge clk_i);
            check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
